// File: rtl/oport_uart_tx.sv
// oport_uart_tx: queues every change of the CPU output port and sends it
// as a UART frame (1 start, 8 data LSB first, 1 stop) on tx.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous reset, active-high
//   oport      - CPU output port value, sampled every clock
//   tx         - serial line, idle high
//   busy       - FIFO non-empty or a frame in flight
//   fifo_count - bytes currently queued
//   overflow   - sticky, a change was dropped on a full FIFO
// Build option: define OPORT_PARITY_EN to append an even-parity bit
// after data bit 7 (11-bit frame instead of 10).
module oport_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    oport,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(CLKS_PER_BIT);

`ifdef OPORT_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } state_t;
`endif

   state_t          r_state;
   logic [TW-1:0]   r_timer;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic            r_tx;
`ifdef OPORT_PARITY_EN
   logic            r_par;
`endif

   logic [7:0]      r_prev;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr;
   logic [AW-1:0]   r_rd;
   logic [CW-1:0]   r_count;
   logic            r_ovf;

   logic            w_push;
   logic            w_full;
   logic            w_wr;
   logic            w_nempty;
   logic            w_last;
   logic            w_pop;
   logic [7:0]      w_head;

   assign w_push   = (oport != r_prev);
   assign w_full   = (r_count == CW'(FIFO_DEPTH));
   // A push on a full FIFO is dropped even if a pop happens on this edge.
   assign w_wr     = w_push & ~w_full;
   assign w_nempty = (r_count != '0);
   assign w_last   = (r_timer == TW'(CLKS_PER_BIT - 1));
   assign w_pop    = w_nempty &
                     ((r_state == S_IDLE) |
                      ((r_state == S_STOP) & w_last));
   assign w_head   = r_mem[r_rd];

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr] <= oport;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev  <= 8'h00;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_prev <= oport;
         if (w_wr)  r_wr <= r_wr + 1'b1;
         if (w_pop) r_rd <= r_rd + 1'b1;
         if (w_wr & ~w_pop)      r_count <= r_count + 1'b1;
         else if (~w_wr & w_pop) r_count <= r_count - 1'b1;
         if (w_push & w_full) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
`ifdef OPORT_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift <= w_head;
`ifdef OPORT_PARITY_EN
                  r_par   <= ^w_head;
`endif
                  r_timer <= '0;
                  r_tx    <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_last) begin
                  r_timer <= '0;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_DATA: begin
               if (w_last) begin
                  r_timer <= '0;
                  if (r_bit == 3'd7) begin
`ifdef OPORT_PARITY_EN
                     r_tx    <= r_par;
                     r_state <= S_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
`ifdef OPORT_PARITY_EN
            S_PARITY: begin
               if (w_last) begin
                  r_timer <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_last) begin
                  r_timer <= '0;
                  // Next queued byte starts with no idle gap.
                  if (w_pop) begin
                     r_shift <= w_head;
`ifdef OPORT_PARITY_EN
                     r_par   <= ^w_head;
`endif
                     r_tx    <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign tx         = r_tx;
   assign busy       = (r_state != S_IDLE) | w_nempty;
   assign fifo_count = r_count;
   assign overflow   = r_ovf;

endmodule

// File: tb/tb_oport_uart_tx.sv
// tb_oport_uart_tx: vector table, directed corner sequences and random
// stimulus against a frame-level model of oport_uart_tx.
module tb_oport_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 8;
`ifdef OPORT_PARITY_EN
   localparam int FL = 11 * CPB;
`else
   localparam int FL = 10 * CPB;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] oport;
   logic       tx;
   logic       busy;
   logic [3:0] fifo_count;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   oport_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .oport(oport),
      .tx(tx),
      .busy(busy),
      .fifo_count(fifo_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Model: queue of bytes plus one frame described by its age in cycles.
   logic [7:0] q[$];
   logic       m_act;
   int         m_age;
   logic [7:0] m_byte;
   logic [7:0] m_prev;
   logic       m_ovf;

   function automatic logic m_tx();
      int b;
      if (!m_act) return 1'b1;
      b = m_age / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_byte[b-1];
`ifdef OPORT_PARITY_EN
      if (b == 9) return ^m_byte;
`endif
      return 1'b1;
   endfunction

   task automatic model_step(input logic rst, input logic [7:0] v);
      logic full;
      if (rst) begin
         q.delete();
         m_act  = 1'b0;
         m_age  = 0;
         m_prev = 8'h00;
         m_ovf  = 1'b0;
         return;
      end
      full = (q.size() == DEPTH);
      if (!m_act) begin
         if (q.size() > 0) begin
            m_byte = q.pop_front();
            m_act  = 1'b1;
            m_age  = 0;
         end
      end else if (m_age == FL - 1) begin
         m_age = 0;
         if (q.size() > 0) m_byte = q.pop_front();
         else m_act = 1'b0;
      end else begin
         m_age++;
      end
      if (v != m_prev) begin
         if (full) m_ovf = 1'b1;
         else q.push_back(v);
      end
      m_prev = v;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d",
                  name, $time, act, exp);
      end
   endtask

   task automatic cyc(input logic rst, input logic [7:0] v);
      reset = rst;
      oport = v;
      @(posedge clk);
      model_step(rst, v);
      #1;
      chk("tx", tx, m_tx());
      chk("busy", busy, int'(m_act || q.size() > 0));
      chk("fifo_count", fifo_count, q.size());
      chk("overflow", overflow, m_ovf);
   endtask

   typedef struct {
      logic       rst;
      logic [7:0] v;
      logic       tx;
      logic       busy;
      logic [3:0] cnt;
      logic       ovf;
   } vec_t;

   vec_t tv[15];

   initial begin
      int n;
      int peak;
      int ones;
      logic [7:0] v;

      tv[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0};
      tv[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0};
      tv[2]  = '{1'b0, 8'h3D, 1'b1, 1'b1, 4'd1, 1'b0};
      tv[3]  = '{1'b0, 8'h3D, 1'b0, 1'b1, 4'd0, 1'b0};
      tv[4]  = '{1'b0, 8'h3D, 1'b0, 1'b1, 4'd0, 1'b0};
      tv[5]  = '{1'b0, 8'h3D, 1'b0, 1'b1, 4'd0, 1'b0};
      tv[6]  = '{1'b0, 8'h3D, 1'b0, 1'b1, 4'd0, 1'b0};
      tv[7]  = '{1'b0, 8'h3D, 1'b1, 1'b1, 4'd0, 1'b0};
      tv[8]  = '{1'b0, 8'h3D, 1'b1, 1'b1, 4'd0, 1'b0};
      tv[9]  = '{1'b0, 8'h3D, 1'b1, 1'b1, 4'd0, 1'b0};
      tv[10] = '{1'b0, 8'h3D, 1'b1, 1'b1, 4'd0, 1'b0};
      tv[11] = '{1'b0, 8'h3D, 1'b0, 1'b1, 4'd0, 1'b0};
      tv[12] = '{1'b0, 8'h3E, 1'b0, 1'b1, 4'd1, 1'b0};
      tv[13] = '{1'b1, 8'h3E, 1'b1, 1'b0, 4'd0, 1'b0};
      tv[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0};

      reset = 1'b1;
      oport = 8'h00;
      cyc(1'b1, 8'h00);
      cyc(1'b1, 8'h00);

      // Idle with oport held at 00.
      for (int i = 0; i < 100; i++) cyc(1'b0, 8'h00);

      // Vector table.
      for (int i = 0; i < 15; i++) begin
         cyc(tv[i].rst, tv[i].v);
         chk($sformatf("tv%0d_tx", i), tx, tv[i].tx);
         chk($sformatf("tv%0d_busy", i), busy, tv[i].busy);
         chk($sformatf("tv%0d_cnt", i), fifo_count, tv[i].cnt);
         chk($sformatf("tv%0d_ovf", i), overflow, tv[i].ovf);
      end

      // Single frame A5: busy drops FL cycles after the pop edge.
      cyc(1'b0, 8'hA5);
      n = 0;
      do begin
         cyc(1'b0, 8'hA5);
         n++;
      end while (busy && n < 200);
      chk("a5_busy_fall", n, FL + 1);

      // Back-to-back frames 01,02,03.
      cyc(1'b0, 8'h01);
      cyc(1'b0, 8'h02);
      cyc(1'b0, 8'h03);
      for (int k = 4; k <= 3 * FL + 5; k++) begin
         cyc(1'b0, 8'h03);
         for (int j = 1; j < 3; j++) begin
            if (k == 1 + j * FL) chk($sformatf("b2b_stop%0d", j), tx, 1);
            if (k == 2 + j * FL) chk($sformatf("b2b_start%0d", j), tx, 0);
         end
      end
      chk("b2b_ovf", overflow, 0);
      chk("b2b_idle", busy, 0);

      // Ten consecutive changes overflow an 8-entry FIFO.
      peak = 0;
      for (int i = 1; i <= 10; i++) begin
         v = 8'(i);
         cyc(1'b0, v);
         if (int'(fifo_count) > peak) peak = fifo_count;
         if (i == 9)  chk("ovf_before_0a", overflow, 0);
         if (i == 10) chk("ovf_at_0a", overflow, 1);
      end
      chk("ovf_peak", peak, DEPTH);
      n = 0;
      while (busy && n < 12 * FL) begin
         cyc(1'b0, 8'h0A);
         n++;
      end
      chk("ovf_drained", busy, 0);

      // Reset in data bit 3 with two bytes queued.
      cyc(1'b0, 8'h11);
      cyc(1'b0, 8'h22);
      cyc(1'b0, 8'h33);
      for (int i = 0; i < 16; i++) cyc(1'b0, 8'h33);
      chk("rst_cnt_before", fifo_count, 2);
      cyc(1'b1, 8'h00);
      chk("rst_tx", tx, 1);
      chk("rst_cnt", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
      ones = 0;
      for (int i = 0; i < 50; i++) begin
         cyc(1'b0, 8'h00);
         if (tx && !busy) ones++;
      end
      chk("rst_no_resume", ones, 50);

`ifdef OPORT_PARITY_EN
      // Parity frame for 07.
      cyc(1'b0, 8'h07);
      n = 0;
      do begin
         cyc(1'b0, 8'h07);
         n++;
         if (n == 36) chk("par_bit7", tx, 0);
         if (n == 37) chk("par_bit", tx, 1);
      end while (busy && n < 200);
      chk("par_frame_len", n, 45);
`endif

      // Random changes, repeats, bursts and occasional reset.
      v = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            v = 8'h00;
            cyc(1'b1, v);
         end else begin
            if ($urandom_range(0, 29) == 0) begin
               for (int b = $urandom_range(1, 10); b > 0; b--) begin
                  v = 8'($urandom_range(0, 255));
                  cyc(1'b0, v);
               end
            end else if ($urandom_range(0, 19) == 0) begin
               v = 8'($urandom_range(0, 3));
            end
            cyc(1'b0, v);
         end
      end
      n = 0;
      while (busy && n < 12 * FL) begin
         cyc(1'b0, v);
         n++;
      end
      chk("rand_drained", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
